// File: rtl/remap_arbiter.sv
// rtl/remap_arbiter.sv - arbitrates SoC lookups and GC/flash-write remap updates onto one remapping table port
module remap_arbiter #(
  parameter int VA_W       = 16,
  parameter int FA_W       = 20,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            soc_req,
  input  logic [VA_W-1:0] soc_vaddr,
  output logic            soc_ack,
  output logic [FA_W-1:0] soc_faddr,
  output logic            soc_err,

  input  logic            gc_req,
  input  logic [VA_W-1:0] gc_vaddr,
  input  logic [FA_W-1:0] gc_faddr,
  output logic            gc_ack,

  input  logic            fl_req,
  input  logic [VA_W-1:0] fl_vaddr,
  input  logic [FA_W-1:0] fl_faddr,
  output logic            fl_ack,

  output logic            rt_lookup,
  output logic            rt_update,
  output logic [VA_W-1:0] rt_vaddr,
  output logic [FA_W-1:0] rt_faddr,
  input  logic            rt_done,
  input  logic            rt_error,
  input  logic [FA_W-1:0] rt_rdata,

  output logic            busy,
  output logic            upd_err
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_SOC, SRC_GC, SRC_FL} src_t;

  // Last cycle of a command that never sees rt_done; the command is high for TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

  state_t     state;
  src_t       owner;
  src_t       pick;
  logic       rr_fl;
  logic [7:0] tcnt;
  logic [7:0] starve;
  logic       upd_pend;
  logic       soc_force;
  logic       cmd_end;
  logic       cmd_fail;

  // Choose the grantee: updates beat lookups unless the lookup has been starved,
  // and gc/fl alternate through the last-served pointer.
  always_comb begin
    upd_pend  = gc_req | fl_req;
    soc_force = soc_req & (starve >= STARVE_MAX);
    pick      = SRC_NONE;
    if (soc_req && (!upd_pend || soc_force)) begin
      pick = SRC_SOC;
    end else if (gc_req && (!fl_req || !rr_fl)) begin
      pick = SRC_GC;
    end else if (fl_req) begin
      pick = SRC_FL;
    end
  end

  // A command ends on rt_done or on its last allowed cycle; done wins over timeout.
  always_comb begin
    cmd_end  = rt_done || (tcnt == TMO_LAST);
    cmd_fail = rt_done ? rt_error : 1'b1;
  end

  // Arbitration, command issue, completion and response sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= SRC_NONE;
      rr_fl     <= 1'b0;
      tcnt      <= '0;
      starve    <= '0;
      soc_ack   <= 1'b0;
      soc_faddr <= '0;
      soc_err   <= 1'b0;
      gc_ack    <= 1'b0;
      fl_ack    <= 1'b0;
      rt_lookup <= 1'b0;
      rt_update <= 1'b0;
      rt_vaddr  <= '0;
      rt_faddr  <= '0;
      busy      <= 1'b0;
      upd_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != SRC_NONE) begin
            owner <= pick;
            tcnt  <= '0;
            busy  <= 1'b1;
            case (pick)
              SRC_SOC: begin
                state     <= LOOKUP;
                rt_lookup <= 1'b1;
                rt_vaddr  <= soc_vaddr;
                rt_faddr  <= '0;
                starve    <= '0;
              end
              SRC_GC: begin
                state     <= UPDATE;
                rt_update <= 1'b1;
                rt_vaddr  <= gc_vaddr;
                rt_faddr  <= gc_faddr;
                rr_fl     <= 1'b1;
              end
              SRC_FL: begin
                state     <= UPDATE;
                rt_update <= 1'b1;
                rt_vaddr  <= fl_vaddr;
                rt_faddr  <= fl_faddr;
                rr_fl     <= 1'b0;
              end
              default: begin
              end
            endcase
            // Only updates that overtake a waiting lookup count toward starvation.
            if (pick != SRC_SOC && soc_req && starve != 8'hFF) begin
              starve <= starve + 8'd1;
            end
          end
        end

        LOOKUP, UPDATE: begin
          if (cmd_end) begin
            rt_lookup <= 1'b0;
            rt_update <= 1'b0;
            state     <= RESP;
            case (owner)
              SRC_SOC: begin
                soc_ack <= 1'b1;
                soc_err <= cmd_fail;
                if (rt_done) begin
                  soc_faddr <= rt_rdata;
                end
              end
              SRC_GC: begin
                gc_ack <= 1'b1;
                if (cmd_fail) begin
                  upd_err <= 1'b1;
                end
              end
              SRC_FL: begin
                fl_ack <= 1'b1;
                if (cmd_fail) begin
                  upd_err <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        RESP: begin
          soc_ack <= 1'b0;
          gc_ack  <= 1'b0;
          fl_ack  <= 1'b0;
          soc_err <= 1'b0;
          busy    <= 1'b0;
          owner   <= SRC_NONE;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remap_arbiter.sv
// tb/tb_remap_arbiter.sv - randomized transaction-level check of remap_arbiter against a reference model
module tb_remap_arbiter;
  localparam int VA_W = 16;
  localparam int FA_W = 20;
  localparam int TIMEOUT = 255;
  localparam int STARVE_LIM = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            soc_req = 1'b0, gc_req = 1'b0, fl_req = 1'b0;
  logic [VA_W-1:0] soc_vaddr = '0, gc_vaddr = '0, fl_vaddr = '0;
  logic [FA_W-1:0] gc_faddr = '0, fl_faddr = '0;
  logic            soc_ack, soc_err, gc_ack, fl_ack;
  logic [FA_W-1:0] soc_faddr;
  logic            rt_lookup, rt_update;
  logic [VA_W-1:0] rt_vaddr;
  logic [FA_W-1:0] rt_faddr;
  logic            rt_done = 1'b0, rt_error = 1'b0;
  logic [FA_W-1:0] rt_rdata = '0;
  logic            busy, upd_err;

  always #5 clk = ~clk;

  remap_arbiter #(.VA_W(VA_W), .FA_W(FA_W), .TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .soc_req(soc_req), .soc_vaddr(soc_vaddr), .soc_ack(soc_ack), .soc_faddr(soc_faddr), .soc_err(soc_err),
    .gc_req(gc_req), .gc_vaddr(gc_vaddr), .gc_faddr(gc_faddr), .gc_ack(gc_ack),
    .fl_req(fl_req), .fl_vaddr(fl_vaddr), .fl_faddr(fl_faddr), .fl_ack(fl_ack),
    .rt_lookup(rt_lookup), .rt_update(rt_update), .rt_vaddr(rt_vaddr), .rt_faddr(rt_faddr),
    .rt_done(rt_done), .rt_error(rt_error), .rt_rdata(rt_rdata),
    .busy(busy), .upd_err(upd_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Requester index: 0 = soc, 1 = gc, 2 = fl
  bit              req_v[3];
  logic [VA_W-1:0] va[3];
  logic [FA_W-1:0] fa[3];

  // Reference model state
  bit              rr_next_fl;
  int              starve_m;
  bit              upd_err_m;
  logic [FA_W-1:0] faddr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    soc_req = req_v[0]; soc_vaddr = va[0];
    gc_req = req_v[1]; gc_vaddr = va[1]; gc_faddr = fa[1];
    fl_req = req_v[2]; fl_vaddr = va[2]; fl_faddr = fa[2];
  endtask

  task automatic reset_model();
    rr_next_fl = 1'b0;
    starve_m = 0;
    upd_err_m = 1'b0;
    faddr_m = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rt_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  // Grant decision from the pending set: updates first, alternating gc/fl,
  // unless a lookup has already been overtaken STARVE_LIM times.
  function automatic int predict();
    bit any_upd;
    any_upd = req_v[1] || req_v[2];
    if (req_v[0] && (!any_upd || starve_m >= STARVE_LIM)) return 0;
    if (req_v[1] && req_v[2]) return rr_next_fl ? 2 : 1;
    if (req_v[1]) return 1;
    if (req_v[2]) return 2;
    return -1;
  endfunction

  task automatic grant_model(input int g);
    if (g == 0) begin
      starve_m = 0;
    end else begin
      if (req_v[0]) starve_m++;
      rr_next_fl = (g == 1);
    end
  endtask

  // Called on an IDLE negedge with requests driven. Arbitration happens on the
  // next posedge; the command then stays up for lat+1 cycles before rt_done.
  task automatic run_txn(input int lat, input bit err, input logic [FA_W-1:0] rdata);
    int g;
    g = predict();
    if (g < 0) return;
    grant_model(g);
    @(negedge clk);
    for (int i = 0; i <= lat; i++) begin
      check("cmd_busy", busy, 1);
      check("rt_lookup", rt_lookup, (g == 0));
      check("rt_update", rt_update, (g != 0));
      check("rt_vaddr", rt_vaddr, va[g]);
      check("rt_faddr", rt_faddr, (g == 0) ? '0 : fa[g]);
      check("cmd_no_ack", {soc_ack, gc_ack, fl_ack}, 0);
      if (i == lat) begin
        rt_done = 1'b1; rt_error = err; rt_rdata = rdata;
      end else begin
        rt_done = 1'b0; rt_error = $urandom_range(1); rt_rdata = FA_W'($urandom);
      end
      @(negedge clk);
    end
    // Response cycle; rt_done noise here and in the following IDLE must be ignored.
    rt_done = $urandom_range(1); rt_error = $urandom_range(1); rt_rdata = FA_W'($urandom);
    check("soc_ack", soc_ack, (g == 0));
    check("gc_ack", gc_ack, (g == 1));
    check("fl_ack", fl_ack, (g == 2));
    check("resp_cmd_low", {rt_lookup, rt_update}, 0);
    check("resp_busy", busy, 1);
    if (g == 0) begin
      faddr_m = rdata;
      check("soc_faddr", soc_faddr, faddr_m);
      check("soc_err", soc_err, err);
    end else begin
      if (err) upd_err_m = 1'b1;
      check("soc_err_upd", soc_err, 0);
    end
    req_v[g] = 1'b0;
    drive_reqs();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_acks", {soc_ack, gc_ack, fl_ack}, 0);
    check("idle_cmd", {rt_lookup, rt_update}, 0);
    check("soc_faddr_hold", soc_faddr, faddr_m);
    check("upd_err", upd_err, upd_err_m);
  endtask

  task automatic set_req(input int k, input logic [VA_W-1:0] v, input logic [FA_W-1:0] f);
    req_v[k] = 1'b1; va[k] = v; fa[k] = f;
  endtask

  initial begin
    int cnt;
    int g;
    for (int k = 0; k < 3; k++) begin
      req_v[k] = 1'b0; va[k] = '0; fa[k] = '0;
    end
    reset_model();
    drive_reqs();

    // Reset values
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_acks", {soc_ack, gc_ack, fl_ack}, 0);
    check("rst_cmd", {rt_lookup, rt_update}, 0);
    check("rst_errs", {soc_err, upd_err}, 0);
    check("rst_soc_faddr", soc_faddr, 0);
    check("rst_rt_vaddr", rt_vaddr, 0);
    check("rst_rt_faddr", rt_faddr, 0);
    do_reset();

    // Basic lookup at minimum latency, then error / no-error lookups
    set_req(0, 16'h0012, '0); drive_reqs();
    run_txn(0, 1'b0, 20'h0ABCD);
    set_req(0, 16'h0345, '0); drive_reqs();
    run_txn(2, 1'b1, 20'h11111);
    set_req(0, 16'h0346, '0); drive_reqs();
    run_txn(0, 1'b0, 20'h22222);

    // gc and fl held together: gc, fl, gc
    do_reset();
    set_req(1, 16'h1111, 20'hA1111); set_req(2, 16'h2222, 20'hB2222); drive_reqs();
    for (int i = 0; i < 3; i++) begin
      run_txn(0, 1'b0, '0);
      req_v[1] = 1'b1; req_v[2] = 1'b1; drive_reqs();
    end

    // Starvation: soc waits behind exactly STARVE_LIM updates
    do_reset();
    set_req(0, 16'h0777, '0); set_req(1, 16'h1234, 20'h01234); set_req(2, 16'h5678, 20'h05678); drive_reqs();
    for (int i = 0; i < STARVE_LIM + 2; i++) begin
      run_txn(1, 1'b0, 20'h0CAFE);
      req_v[1] = 1'b1; req_v[2] = 1'b1; drive_reqs();
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0; req_v[2] = 1'b0; drive_reqs();

    // Update timeout
    do_reset();
    set_req(1, 16'h00A5, 20'h12345); drive_reqs();
    g = predict();
    grant_model(g);
    @(negedge clk);
    cnt = 0;
    while (rt_update && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_len", cnt, TIMEOUT);
    check("timeout_gc_ack", gc_ack, 1);
    check("timeout_upd_err", upd_err, 1);
    upd_err_m = 1'b1;
    req_v[1] = 1'b0; drive_reqs();
    @(negedge clk);
    check("timeout_idle_busy", busy, 0);
    set_req(0, 16'h0099, '0); drive_reqs();
    run_txn(0, 1'b0, 20'h00099);
    do_reset();
    check("upd_err_cleared", upd_err, 0);

    // Reset in the middle of an update
    set_req(1, 16'h0BEE, 20'h0F00D); drive_reqs();
    g = predict();
    grant_model(g);
    @(negedge clk);
    check("mid_rt_update", rt_update, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rt_update", rt_update, 0);
    check("async_busy", busy, 0);
    check("async_gc_ack", gc_ack, 0);
    @(negedge clk);
    check("rst_no_ack", {soc_ack, gc_ack, fl_ack}, 0);
    rst = 1'b0;
    reset_model();
    rt_done = 1'b0;
    run_txn(1, 1'b0, '0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (!req_v[k] && $urandom_range(99) < 55)
          set_req(k, VA_W'($urandom), FA_W'($urandom));
      end
      if (!req_v[0] && !req_v[1] && !req_v[2]) begin
        g = $urandom_range(2);
        set_req(g, VA_W'($urandom), FA_W'($urandom));
      end
      drive_reqs();
      run_txn($urandom_range(3), ($urandom_range(7) == 0), FA_W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
